// File: rtl/serial_pkg.sv
// Shared encodings and defaults for the parameterised serial receiver.
// Provides the FSM state type, parity-mode constants and default bit period.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    localparam int PAR_NONE    = 0;
    localparam int PAR_ODD     = 1;
    localparam int PAR_EVEN    = 2;
    localparam int DEF_CLK_DIV = 52;

endpackage

// File: rtl/serial_sync_vote.sv
// Two-flop rx synchronizer plus falling-edge detect and 3-tap majority vote.
// Latency: edge flagged 2 cycles after rx is captured; no backpressure.
module serial_sync_vote (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic fall_o,
    output logic vote_o
);

    logic s1_q, s2_q, d1_q, d2_q;

    // All stages reset to the idle-high line level so reset never looks like a start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            d1_q <= 1'b1;
            d2_q <= 1'b1;
        end else begin
            s1_q <= rx_i;
            s2_q <= s1_q;
            d1_q <= s2_q;
            d2_q <= d1_q;
        end
    end

    assign fall_o = d1_q & ~s2_q;
    assign vote_o = (s2_q & d1_q) | (s2_q & d2_q) | (d1_q & d2_q);

endmodule

// File: rtl/serial_rx_param.sv
// UART receiver with configurable period, width, parity and stop bits; frame held until acked.
// Latency: rx_valid rises the cycle after the last stop-bit vote; an unacked frame drops newer ones and sets overrun.
module serial_rx_param
    import serial_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk12,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW   = $clog2(CLK_DIV);
    localparam int HALF = CLK_DIV / 2;

    logic                 fall, vote;
    state_t               state_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q, byte_q;
    logic                 perr_q, ferr_q;
    logic                 valid_q, perr_out_q, ferr_out_q, ovr_q;
    logic                 tick, done, frame_bad, par_calc, ack_acc;

    serial_sync_vote u_sync (
        .clk_i  (clk12),
        .rst_i  (rst),
        .rx_i   (rx),
        .fall_o (fall),
        .vote_o (vote)
    );

    always_comb begin
        tick      = (state_q != ST_IDLE) && (cnt_q == CW'(HALF + 1));
        done      = tick && (state_q == ST_STOP) && (bit_q == 4'(STOP_BITS - 1));
        frame_bad = ferr_q | ~vote;
        par_calc  = (^shift_q) ^ (PARITY == PAR_ODD);
        ack_acc   = rx_ack & valid_q;

        // Count 0 is the start-detect cycle itself, so the first active cycle reads 1.
        cnt_d = cnt_q;
        if (state_q == ST_IDLE)
            cnt_d = fall ? CW'(1) : '0;
        else if (done || (tick && (state_q == ST_START) && vote))
            cnt_d = '0;
        else if (cnt_q == CW'(CLK_DIV - 1))
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk12) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                ST_IDLE: if (fall) begin
                    state_q <= ST_START;
                    bit_q   <= '0;
                    perr_q  <= 1'b0;
                    ferr_q  <= 1'b0;
                end
                ST_START: if (tick) begin
                    state_q <= vote ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (tick) begin
                    shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_q   <= '0;
                        state_q <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_q <= bit_q + 4'd1;
                    end
                end
                ST_PAR: if (tick) begin
                    perr_q  <= vote ^ par_calc;
                    state_q <= ST_STOP;
                end
                ST_STOP: if (tick) begin
                    ferr_q <= frame_bad;
                    if (bit_q == 4'(STOP_BITS - 1))
                        state_q <= ST_IDLE;
                    else
                        bit_q <= bit_q + 4'd1;
                end
                default: state_q <= ST_IDLE;
            endcase

            // A completing frame may replace the held one only if it is being acked this cycle.
            if (done && (!valid_q || rx_ack)) begin
                byte_q     <= shift_q;
                perr_out_q <= perr_q;
                ferr_out_q <= frame_bad;
                valid_q    <= 1'b1;
            end else if (ack_acc) begin
                valid_q <= 1'b0;
            end

            if (done && valid_q && !rx_ack)
                ovr_q <= 1'b1;
            else if (ack_acc)
                ovr_q <= 1'b0;
        end
    end

    assign rx_byte    = byte_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_rx_param.sv
// Directed bench for serial_rx_param: a default 8N1 instance and an 8E2 instance at 16 cycles/bit.
// Expected frames are queued as they are transmitted and checked when rx_valid rises.
module tb_serial_rx_param;

    localparam int CD0 = 52;
    localparam int CD1 = 16;

    typedef struct packed {
        logic [7:0] b;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk12 = 1'b0;
    logic       rst, rx0, rx1, rx_ack0, rx_ack1;
    logic [7:0] rx_byte0, rx_byte1;
    logic       rx_valid0, rx_valid1, parity_err0, parity_err1;
    logic       frame_err0, frame_err1, overrun0, overrun1;
    logic       v0_prev = 1'b0;
    logic       v1_prev = 1'b0;
    exp_t       q0[$];
    exp_t       q1[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    always #5 clk12 = ~clk12;

    serial_rx_param u_dut0 (
        .clk12(clk12), .rst(rst), .rx(rx0), .rx_byte(rx_byte0), .rx_valid(rx_valid0),
        .rx_ack(rx_ack0), .parity_err(parity_err0), .frame_err(frame_err0), .overrun(overrun0)
    );

    serial_rx_param #(.CLK_DIV(CD1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk12(clk12), .rst(rst), .rx(rx1), .rx_byte(rx_byte1), .rx_valid(rx_valid1),
        .rx_ack(rx_ack1), .parity_err(parity_err1), .frame_err(frame_err1), .overrun(overrun1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic b, input int n);
        if (which == 0) rx0 = b;
        else            rx1 = b;
        repeat (n) @(posedge clk12);
        #1;
    endtask

    // gbit selects a bit to receive a one-cycle inverted glitch mid-bit (-1 for none).
    task automatic send(input int which, input logic [7:0] d, input logic pbit,
                        input logic [1:0] stops, input int gbit, input bit exp_out);
        logic [11:0] bits;
        int          cd, nb;
        exp_t        e;
        cd   = (which == 0) ? CD0 : CD1;
        nb   = (which == 0) ? 10 : 12;
        bits = (which == 0) ? {2'b11, stops[0], d, 1'b0} : {stops[1], stops[0], pbit, d, 1'b0};
        e.b  = d;
        e.pe = (which == 0) ? 1'b0 : (pbit ^ (^d));
        e.fe = (which == 0) ? ~stops[0] : ~(&stops);
        if (exp_out) begin
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        for (int i = 0; i < nb; i++) begin
            if (i == gbit) begin
                drive(which, bits[i], cd / 2);
                drive(which, ~bits[i], 1);
                drive(which, bits[i], cd - cd / 2 - 1);
            end else begin
                drive(which, bits[i], cd);
            end
        end
        if (which == 0) rx0 = 1'b1;
        else            rx1 = 1'b1;
    endtask

    task automatic ack(input int which);
        if (which == 0) rx_ack0 = 1'b1;
        else            rx_ack1 = 1'b1;
        @(posedge clk12);
        #1;
        rx_ack0 = 1'b0;
        rx_ack1 = 1'b0;
        if (which == 0) check("ack0_valid_clear", 32'(rx_valid0), 0);
        else            check("ack1_valid_clear", 32'(rx_valid1), 0);
    endtask

    always @(negedge clk12) begin
        if (rx_valid0 && !v0_prev) begin
            check("d0_frame_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                check("d0_byte", 32'(rx_byte0), 32'(q0[0].b));
                check("d0_parity_err", 32'(parity_err0), 32'(q0[0].pe));
                check("d0_frame_err", 32'(frame_err0), 32'(q0[0].fe));
                q0.delete(0);
            end
        end
        if (rx_valid1 && !v1_prev) begin
            check("d1_frame_expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                check("d1_byte", 32'(rx_byte1), 32'(q1[0].b));
                check("d1_parity_err", 32'(parity_err1), 32'(q1[0].pe));
                check("d1_frame_err", 32'(frame_err1), 32'(q1[0].fe));
                q1.delete(0);
            end
        end
        v0_prev <= rx_valid0;
        v1_prev <= rx_valid1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rx_ack0 = 1'b0; rx_ack1 = 1'b0;
        repeat (3) @(posedge clk12);
        #1;
        rst = 1'b0;
        check("rst_valid0", 32'(rx_valid0), 0);
        check("rst_byte0", 32'(rx_byte0), 0);
        check("rst_flags0", 32'({parity_err0, frame_err0, overrun0}), 0);
        check("rst_valid1", 32'(rx_valid1), 0);
        check("rst_flags1", 32'({parity_err1, frame_err1, overrun1}), 0);
        drive(0, 1'b1, 10);

        // Exact completion latency of a default 8N1 frame.
        fork
            send(0, 8'hA5, 1'b0, 2'b11, -1, 1'b1);
            begin
                repeat (497) @(posedge clk12);
                #1;
                check("a5_valid_before", 32'(rx_valid0), 0);
                @(posedge clk12);
                #1;
                check("a5_valid_at", 32'(rx_valid0), 1);
            end
        join
        ack(0);
        check("a5_overrun", 32'(overrun0), 0);

        send(0, 8'h00, 1'b0, 2'b11, 3, 1'b1);
        ack(0);
        send(0, 8'hFF, 1'b0, 2'b11, 6, 1'b1);
        ack(0);
        send(0, 8'h5A, 1'b0, 2'b11, -1, 1'b1);
        ack(0);

        send(0, 8'h55, 1'b0, 2'b10, -1, 1'b1);
        drive(0, 1'b1, 20);
        ack(0);

        drive(0, 1'b0, 10);
        drive(0, 1'b1, 200);
        check("glitch_no_valid", 32'(rx_valid0), 0);

        send(0, 8'h11, 1'b0, 2'b11, -1, 1'b1);
        send(0, 8'h22, 1'b0, 2'b11, -1, 1'b0);
        drive(0, 1'b1, 10);
        check("ovr_valid", 32'(rx_valid0), 1);
        check("ovr_byte_held", 32'(rx_byte0), 32'h11);
        check("ovr_set", 32'(overrun0), 1);
        ack(0);
        check("ovr_cleared", 32'(overrun0), 0);

        // Abandon a frame with reset during data bit 4, then resend cleanly.
        drive(0, 1'b0, CD0);
        drive(0, 1'b1, CD0);
        drive(0, 1'b0, CD0);
        drive(0, 1'b1, CD0);
        drive(0, 1'b0, CD0);
        drive(0, 1'b0, 20);
        rst = 1'b1;
        drive(0, 1'b0, 3);
        rst = 1'b0;
        drive(0, 1'b1, 60);
        check("rst_mid_valid", 32'(rx_valid0), 0);
        send(0, 8'h3C, 1'b0, 2'b11, -1, 1'b1);
        drive(0, 1'b1, 10);
        ack(0);

        send(1, 8'h03, 1'b1, 2'b11, -1, 1'b1);
        ack(1);
        send(1, 8'h03, 1'b0, 2'b11, -1, 1'b1);
        ack(1);
        send(1, 8'hC6, 1'b0, 2'b01, -1, 1'b1);
        drive(1, 1'b1, 20);
        ack(1);
        send(1, 8'h80, 1'b1, 2'b11, -1, 1'b1);
        ack(1);

        drive(0, 1'b1, 20);
        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
